cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller directly upstream of the cache top level.
- On a cache miss it fetches the full 16-byte block (8 words) from main memory and streams each returned word into the data array (cacheop FILL).
- It then commits the tag, valid and LRU update in one cycle (cacheop SET_TAG) and releases the pipeline stall.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; must be a power of two.
- ADDR_W, 16, address width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  cache miss flag for the current access.
- miss_address  in  ADDR_W  address of the missing access.
- memory_data  in  16  read data returned by main memory.
- memory_data_valid  in  1  memory_data holds the word for the oldest outstanding request.
- fsm_busy  out  1  stall request to the pipeline.
- memory_en  out  1  issues one memory read request this cycle.
- memory_address  out  ADDR_W  address of the issued request.
- cache_en  out  1  drives r_enabled of the cache during fills.
- cacheop  out  2  cache operation: 00 READ, 01 FILL, 10 SET_TAG.
- cache_address  out  ADDR_W  address presented to the cache while the FSM is busy.
- cache_data  out  16  fill data written into the cache.

Behaviour:
- States: IDLE, FETCH, TAG. Encoded as 2 bits: 00, 01, 10.
- Reset:
  - State goes to IDLE.
  - issue_cnt and recv_cnt go to 0.
  - Latched miss address goes to 0.
  - All outputs are 0 (cacheop=00).
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall asserts in the miss cycle itself).
  - When miss_detected=1: latch miss_address[ADDR_W-1:4] as blk, clear both counters, next state FETCH.
  - memory_data_valid is ignored.
- FETCH:
  - fsm_busy = 1; cache_en = 1.
  - Issue side:
    - While issue_cnt < BLOCK_WORDS: memory_en = 1 and memory_address = {blk, issue_cnt[2:0], 1'b0}; issue_cnt increments.
    - Exactly one request per cycle; 8 requests in 8 consecutive cycles.
    - Once all 8 are issued, memory_en = 0.
  - Receive side, on each memory_data_valid=1:
    - cacheop = 01.
    - cache_address = {blk, recv_cnt[2:0], 1'b0}; cache_data = memory_data.
    - recv_cnt increments.
  - With no valid this cycle: cacheop = 00 and cache_data = 0.
  - Issue and receive run independently. A request and a return in the same cycle are both handled.
  - Memory returns data in request order; no reordering logic.
  - When the 8th valid is accepted (recv_cnt goes 7 to 8), next state is TAG.
- TAG:
  - One cycle only: cacheop = 10, cache_address = {blk, 4'b0000}, cache_en = 1, fsm_busy = 1.
  - Next state IDLE.
  - fsm_busy drops the following cycle; the pipeline then replays the access, which hits.
- Boundary conditions:
  - miss_detected is ignored outside IDLE.
  - memory_data_valid is ignored outside FETCH, and also when recv_cnt = BLOCK_WORDS. No counter overflow.
  - Counters are log2(BLOCK_WORDS)+1 bits wide and saturate at BLOCK_WORDS.
  - Reset mid-operation: immediate return to IDLE with everything cleared, no tag write. Main memory shares rst, so no returns are in flight after reset.
  - The data array is written before the tag, so the transaction commits atomically in TAG and LRU changes only there.
- Latency: with memory latency L (request in cycle t, valid in cycle t+L) and miss detected in cycle 0:
  - Requests are issued in cycles 1..8.
  - Fills occur in cycles 1+L..8+L.
  - TAG is in cycle 9+L.
  - fsm_busy is low in cycle 10+L.
- Outputs are registered state decodes except fsm_busy in IDLE, the FETCH data path (cache_data and cacheop follow memory_data_valid), and memory_address.

Decomposition:
- Shared package cache_pkg holds:
  - CACHEOP_READ = 2'b00, CACHEOP_FILL = 2'b01, CACHEOP_SET_TAG = 2'b10;
  - the FSM state encodings;
  - BLOCK_OFFSET_BITS = 4.
- One sub-module, fill_word_counter: synchronous clear, enable, saturate at BLOCK_WORDS, done flag.
- It is instantiated twice, for issue_cnt and recv_cnt.

Test Plan:
- Reset → all outputs 0. Assert rst in FETCH after 3 fills → IDLE the next cycle, no SET_TAG issued, a new miss restarts at word 0.
- Miss at 0x1A36 with memory L=4 → memory_address = 0x1A30, 0x1A32 … 0x1A3E in cycles 1–8.
  - Fills in cycles 5–12 at the same addresses, carrying the memory data.
  - cacheop=10 with cache_address=0x1A30 in cycle 13.
  - fsm_busy low in cycle 14.
- Memory with irregular valid gaps (valids 2 cycles apart) → still exactly 8 FILL writes in order. TAG follows only the 8th valid; memory_en stays 0 after request 8.
- miss_detected held high and miss_address changed during FETCH → no re-latch; all addresses keep blk=0x1A3.
- Spurious memory_data_valid in IDLE and in TAG → cacheop unchanged (00 and 10 respectively), counters unchanged.
- Back-to-back misses: second miss asserted in the cycle fsm_busy drops → new FETCH starts the next cycle with fresh counters and its own block address.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache operation codes, fill FSM states and block geometry
package cache_pkg;

   typedef logic [1:0] cacheop_t;

   localparam cacheop_t CACHEOP_READ    = 2'b00;
   localparam cacheop_t CACHEOP_FILL    = 2'b01;
   localparam cacheop_t CACHEOP_SET_TAG = 2'b10;

   localparam int BLOCK_OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      TAG   = 2'b10
   } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - pipeline, main-memory and cache-array signals of the fill controller
interface cache_fill_fsm_if
   import cache_pkg::*;
#(
   parameter int ADDR_W = 16
);

   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic [15:0]       memory_data;
   logic              memory_data_valid;
   logic              fsm_busy;
   logic              memory_en;
   logic [ADDR_W-1:0] memory_address;
   logic              cache_en;
   cacheop_t          cacheop;
   logic [ADDR_W-1:0] cache_address;
   logic [15:0]       cache_data;

   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, memory_en, memory_address, cache_en, cacheop, cache_address, cache_data
   );

   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, memory_en, memory_address, cache_en, cacheop, cache_address, cache_data
   );

endinterface

// File: rtl/fill_word_counter.sv
// rtl/fill_word_counter.sv - word counter for one block fill, saturating at BLOCK_WORDS
module fill_word_counter #(
   parameter  int BLOCK_WORDS = 8,
   localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   assign done = (count == CNT_W'(BLOCK_WORDS));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en && !done) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss handler: fetch one block from memory, fill the data array, then commit the tag
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic            clk,
   input  logic            rst,
   cache_fill_fsm_if.master bus
);

   localparam int WIDX  = $clog2(BLOCK_WORDS);
   localparam int CNT_W = WIDX + 1;
   localparam int BLK_W = ADDR_W - BLOCK_OFFSET_BITS;

   fill_state_t      state_q, state_d;
   logic [BLK_W-1:0] blk_q;
   logic [CNT_W-1:0] issue_cnt, recv_cnt;
   logic             issue_done, recv_done;
   logic             cnt_clear, issue_en, recv_fire;

   logic              busy, mem_en, c_en;
   logic [ADDR_W-1:0] mem_addr, c_addr;
   cacheop_t          op;
   logic [15:0]       c_data;

   logic [BLOCK_OFFSET_BITS-1:0] unused_offset;
   assign unused_offset = bus.miss_address[BLOCK_OFFSET_BITS-1:0];

   function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0] b,
                                                    input logic [CNT_W-1:0] idx);
      return {b, idx[WIDX-1:0], 1'b0};
   endfunction

   assign cnt_clear = (state_q == IDLE) && bus.miss_detected;
   assign issue_en  = (state_q == FETCH) && !issue_done;
   // Returns beyond the eighth are dropped so recv_cnt can never wrap.
   assign recv_fire = (state_q == FETCH) && bus.memory_data_valid && !recv_done;

   fill_word_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .en    (issue_en),
      .count (issue_cnt),
      .done  (issue_done)
   );

   fill_word_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .en    (recv_fire),
      .count (recv_cnt),
      .done  (recv_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         if (cnt_clear) begin
            blk_q <= bus.miss_address[ADDR_W-1:BLOCK_OFFSET_BITS];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      mem_en   = 1'b0;
      mem_addr = '0;
      c_en     = 1'b0;
      op       = CACHEOP_READ;
      c_addr   = '0;
      c_data   = '0;
      case (state_q)
         IDLE: begin
            // Stall in the miss cycle itself so the pipeline never advances past it.
            busy = bus.miss_detected;
            if (bus.miss_detected) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            busy   = 1'b1;
            c_en   = 1'b1;
            c_addr = word_addr(blk_q, recv_cnt);
            if (!issue_done) begin
               mem_en   = 1'b1;
               mem_addr = word_addr(blk_q, issue_cnt);
            end
            if (recv_fire) begin
               op     = CACHEOP_FILL;
               c_data = bus.memory_data;
               if (recv_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                  state_d = TAG;
               end
            end
         end
         TAG: begin
            // Tag, valid and LRU change only here, after every data word is in place.
            busy    = 1'b1;
            c_en    = 1'b1;
            op      = CACHEOP_SET_TAG;
            c_addr  = {blk_q, {BLOCK_OFFSET_BITS{1'b0}}};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.fsm_busy       = busy;
   assign bus.memory_en      = mem_en;
   assign bus.memory_address = mem_addr;
   assign bus.cache_en       = c_en;
   assign bus.cacheop        = op;
   assign bus.cache_address  = c_addr;
   assign bus.cache_data     = c_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cache_fill_fsm_if #(.ADDR_W(16)) bus ();

   cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'd37) ^ 16'hC35A;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},      bus.fsm_busy,       0);
      check({tag, "_mem_en"},    bus.memory_en,      0);
      check({tag, "_mem_addr"},  bus.memory_address, 0);
      check({tag, "_cache_en"},  bus.cache_en,       0);
      check({tag, "_cacheop"},   bus.cacheop,        CACHEOP_READ);
      check({tag, "_cache_adr"}, bus.cache_address,  0);
      check({tag, "_cache_dat"}, bus.cache_data,     0);
   endtask

   task automatic idle_cycle(input string tag, input bit spur);
      @(posedge clk); #1;
      bus.miss_detected     = 1'b0;
      bus.miss_address      = 16'h0000;
      bus.memory_data_valid = spur;
      bus.memory_data       = 16'hFFFF;
      #4;
      check_idle(tag);
      bus.memory_data_valid = 1'b0;
   endtask

   // Miss cycle, FETCH cycles and TAG cycle. Memory returns word k no earlier than
   // (issue cycle k+1) + lat and at least gap cycles after the previous return.
   task automatic run_miss(input string tag, input logic [15:0] addr, input int lat,
                           input int gap, input bit hold, input bit tag_spur,
                           input int stop_fills);
      logic [15:0] base;
      int n_ret, last_ret, due;
      bit v;
      base = {addr[15:4], 4'h0};
      @(posedge clk); #1;
      bus.miss_detected     = 1'b1;
      bus.miss_address      = addr;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'hDEAD;
      #4;
      check({tag, "_c0_busy"},     bus.fsm_busy,  1);
      check({tag, "_c0_mem_en"},   bus.memory_en, 0);
      check({tag, "_c0_cache_en"}, bus.cache_en,  0);
      check({tag, "_c0_cacheop"},  bus.cacheop,   CACHEOP_READ);
      n_ret    = 0;
      last_ret = 0;
      for (int c = 1; c < 200 && n_ret < 8; c++) begin
         @(posedge clk); #1;
         bus.miss_detected = hold;
         bus.miss_address  = hold ? 16'($urandom) : 16'h0000;
         due = n_ret + 1 + lat;
         if (n_ret > 0 && due < last_ret + gap) due = last_ret + gap;
         v = (c >= due);
         bus.memory_data_valid = v;
         bus.memory_data       = v ? mem_word(base + 16'(2 * n_ret)) : 16'hBEEF;
         #4;
         check({tag, "_busy"},     bus.fsm_busy,  1);
         check({tag, "_cache_en"}, bus.cache_en,  1);
         check({tag, "_mem_en"},   bus.memory_en, (c <= 8) ? 1 : 0);
         if (c <= 8) check({tag, "_mem_addr"}, bus.memory_address, base + 16'(2 * (c - 1)));
         if (v) begin
            check({tag, "_fill_op"},   bus.cacheop,       CACHEOP_FILL);
            check({tag, "_fill_addr"}, bus.cache_address, base + 16'(2 * n_ret));
            check({tag, "_fill_data"}, bus.cache_data,    mem_word(base + 16'(2 * n_ret)));
            n_ret++;
            last_ret = c;
         end else begin
            check({tag, "_nofill_op"},   bus.cacheop,    CACHEOP_READ);
            check({tag, "_nofill_data"}, bus.cache_data, 0);
         end
         if (stop_fills != 0 && n_ret == stop_fills) return;
      end
      @(posedge clk); #1;
      bus.memory_data_valid = tag_spur;
      bus.memory_data       = 16'h1234;
      #4;
      check({tag, "_tag_op"},     bus.cacheop,       CACHEOP_SET_TAG);
      check({tag, "_tag_addr"},   bus.cache_address, base);
      check({tag, "_tag_busy"},   bus.fsm_busy,      1);
      check({tag, "_tag_en"},     bus.cache_en,      1);
      check({tag, "_tag_mem_en"}, bus.memory_en,     0);
      bus.memory_data_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                   = 1'b1;
      bus.miss_detected     = 1'b0;
      bus.miss_address      = 16'h0000;
      bus.memory_data       = 16'h0000;
      bus.memory_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #5;
      check_idle("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      idle_cycle("idle_spur", 1'b1);

      run_miss("l4", 16'h1A36, 4, 1, 1'b0, 1'b0, 0);
      idle_cycle("l4_done", 1'b0);

      run_miss("pre_rst", 16'h2B5C, 2, 1, 1'b0, 1'b0, 3);
      @(posedge clk); #1;
      rst                   = 1'b1;
      bus.miss_detected     = 1'b0;
      bus.memory_data_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #4;
      check_idle("after_rst");
      idle_cycle("after_rst2", 1'b0);
      run_miss("restart", 16'h2B5C, 2, 1, 1'b0, 1'b0, 0);
      idle_cycle("restart_done", 1'b0);

      run_miss("gap", 16'h4C8E, 3, 2, 1'b0, 1'b0, 0);
      idle_cycle("gap_done", 1'b0);

      run_miss("hold", 16'h1A36, 1, 1, 1'b1, 1'b1, 0);
      idle_cycle("hold_done", 1'b1);

      run_miss("b2b_a", 16'h7F02, 2, 1, 1'b0, 1'b0, 0);
      run_miss("b2b_b", 16'hE0F4, 5, 1, 1'b0, 1'b0, 0);
      idle_cycle("b2b_done", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
